// File: rtl/weight_tile_sequencer_if.sv
// Byte-stream, weight-FIFO push and MLP-controller handshake signals of the weight tile sequencer.
// slave = sequencer side, master = host/controller side.
interface weight_tile_sequencer_if;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       wf_push_col0;
  logic       wf_push_col1;
  logic       wf_push_col2;
  logic [7:0] wf_data;
  logic       wf_reset;
  logic       weights_ready;
  logic       weights_consumed;
  logic [2:0] tile_idx;
  logic       busy;
  logic       done;
  logic       err_last;

  modport slave (
    input  start, s_valid, s_data, s_last, weights_consumed,
    output s_ready, wf_push_col0, wf_push_col1, wf_push_col2, wf_data, wf_reset,
           weights_ready, tile_idx, busy, done, err_last
  );

  modport master (
    output start, s_valid, s_data, s_last, weights_consumed,
    input  s_ready, wf_push_col0, wf_push_col1, wf_push_col2, wf_data, wf_reset,
           weights_ready, tile_idx, busy, done, err_last
  );
endinterface

// File: rtl/weight_tile_sequencer.sv
// Routes host weight bytes column-major into three column FIFOs, one ROWSxCOLS tile per layer.
// Push follows the accepting handshake by 1 cycle; s_ready is low outside FILL and whenever start is high.
module weight_tile_sequencer #(
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int NUM_LAYERS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  weight_tile_sequencer_if.slave seq
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_READY,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [2:0]      tile_q, tile_d;
  logic            err_q, err_d;
  logic [2:0]      push_q, push_d;
  logic [7:0]      data_q, data_d;
  logic            wf_reset_q;
  logic            wready_q;
  logic            busy_q;
  logic            done_q;
  logic            accept;
  logic            last_byte;
  logic            row_wrap;

  assign seq.s_ready = (state_q == S_FILL) && !seq.start;
  assign accept      = seq.s_ready && seq.s_valid;
  assign row_wrap    = (row_q == RW'(ROWS - 1));
  assign last_byte   = row_wrap && (col_q == 2'(COLS - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tile_d  = tile_q;
    err_d   = err_q;
    push_d  = 3'b000;
    data_d  = data_q;

    if (accept) begin
      push_d = 3'b001 << col_q;
      data_d = seq.s_data;
      // Tile boundary comes from the count; a disagreeing s_last only flags the error.
      if (seq.s_last != last_byte) begin
        err_d = 1'b1;
      end
    end

    if (seq.start) begin
      // Cleared on entry so CLEAR already presents tile 0 and no error.
      state_d = S_CLEAR;
      row_d   = '0;
      col_d   = '0;
      tile_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: state_d = S_FILL;
        S_FILL: begin
          if (accept) begin
            if (row_wrap) begin
              row_d = '0;
              if (col_q == 2'(COLS - 1)) begin
                col_d   = '0;
                state_d = S_READY;
              end else begin
                col_d = col_q + 2'd1;
              end
            end else begin
              row_d = row_q + RW'(1);
            end
          end
        end
        S_READY: begin
          if (seq.weights_consumed) begin
            if (tile_q == 3'(NUM_LAYERS - 1)) begin
              state_d = S_DONE;
            end else begin
              tile_d  = tile_q + 3'd1;
              state_d = S_FILL;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      tile_q     <= '0;
      err_q      <= 1'b0;
      push_q     <= 3'b000;
      data_q     <= 8'h00;
      wf_reset_q <= 1'b0;
      wready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      tile_q     <= tile_d;
      err_q      <= err_d;
      push_q     <= push_d;
      data_q     <= data_d;
      wf_reset_q <= (state_d == S_CLEAR);
      wready_q   <= (state_d == S_READY);
      busy_q     <= (state_d == S_CLEAR) || (state_d == S_FILL) || (state_d == S_READY);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign seq.wf_push_col0  = push_q[0];
  assign seq.wf_push_col1  = push_q[1];
  assign seq.wf_push_col2  = push_q[2];
  assign seq.wf_data       = data_q;
  assign seq.wf_reset      = wf_reset_q;
  assign seq.weights_ready = wready_q;
  assign seq.tile_idx      = tile_q;
  assign seq.busy          = busy_q;
  assign seq.done          = done_q;
  assign seq.err_last      = err_q;

endmodule

// File: tb/tb_weight_tile_sequencer.sv
// Randomised and directed bench for weight_tile_sequencer against a byte-count based reference model.
module tb_weight_tile_sequencer;
  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int NUM_LAYERS = 2;
  localparam int TILE = ROWS * COLS;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_FILL = 2, P_READY = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  weight_tile_sequencer_if bus();

  weight_tile_sequencer #(.ROWS(ROWS), .COLS(COLS), .NUM_LAYERS(NUM_LAYERS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .seq  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         phase;
    int         n;      // bytes accepted so far in the current tile
    int         tile;
    logic       err;
    logic       pv;     // a push is due this cycle
    int         pcol;
    logic [7:0] pdat;
  } model_t;

  model_t m = '0;
  int tests = 0;
  int fails = 0;
  int push_cnt = 0;
  logic [7:0] q0[$], q1[$], q2[$];

  function automatic model_t step(model_t c);
    model_t x = c;
    bit acc;
    acc  = (c.phase == P_FILL) && !bus.start && bus.s_valid;
    x.pv = acc;
    if (acc) begin
      x.pcol = c.n / ROWS;
      x.pdat = bus.s_data;
      if (bus.s_last != (c.n == TILE - 1)) x.err = 1'b1;
      x.n = c.n + 1;
    end
    if (bus.start) begin
      x.phase = P_CLEAR; x.n = 0; x.tile = 0; x.err = 1'b0;
    end else if (c.phase == P_CLEAR) begin
      x.phase = P_FILL;
    end else if (c.phase == P_FILL && x.n == TILE) begin
      x.n = 0; x.phase = P_READY;
    end else if (c.phase == P_READY && bus.weights_consumed) begin
      if (c.tile == NUM_LAYERS - 1) x.phase = P_DONE;
      else begin x.tile = c.tile + 1; x.phase = P_FILL; end
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step(m);
  end

  function automatic logic [19:0] dut_vec();
    return {bus.s_ready, bus.wf_push_col2, bus.wf_push_col1, bus.wf_push_col0, bus.wf_data,
            bus.wf_reset, bus.weights_ready, bus.tile_idx, bus.busy, bus.done, bus.err_last};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    logic [10:0] got, exp;
    logic [2:0] exp_push;
    forever begin
      @(negedge clk);
      exp_push = m.pv ? (3'b001 << m.pcol) : 3'b000;
      got = {bus.s_ready, bus.wf_push_col2, bus.wf_push_col1, bus.wf_push_col0, bus.wf_reset,
             bus.weights_ready, bus.tile_idx, bus.busy, bus.done, bus.err_last};
      exp = {(m.phase == P_FILL) && !bus.start, exp_push, m.phase == P_CLEAR, m.phase == P_READY,
             m.tile[2:0], (m.phase == P_CLEAR) || (m.phase == P_FILL) || (m.phase == P_READY),
             m.phase == P_DONE, m.err};
      tests++;
      if (got !== exp || (m.pv && bus.wf_data !== m.pdat)) begin
        fails++;
        $display("FAIL cycle_check at %0t: got %b data %h, expected %b data %h",
                 $time, got, bus.wf_data, exp, m.pdat);
      end
      if (bus.wf_push_col0) q0.push_back(bus.wf_data);
      if (bus.wf_push_col1) q1.push_back(bus.wf_data);
      if (bus.wf_push_col2) q2.push_back(bus.wf_data);
      if (bus.wf_push_col0 || bus.wf_push_col1 || bus.wf_push_col2) push_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic pulse_consume();
    bus.weights_consumed = 1'b1; tick(); bus.weights_consumed = 1'b0;
  endtask

  task automatic clear_log();
    q0.delete(); q1.delete(); q2.delete(); push_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    int cnt = 0;
    bit got = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
    while (!got && cnt < 50) begin
      @(negedge clk);
      got = bus.s_ready;
      tick();
      cnt++;
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    check("send_handshake", int'(got), 1);
  endtask

  initial begin
    bus.start = 0; bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0; bus.weights_consumed = 0;
    fork compare_loop(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'(dut_vec()), 0);
    #2 rst_n = 1'b1;
    tick();

    // Two-layer run
    pulse_start(); clear_log();
    for (int i = 1; i <= 9; i++) send(8'(i), i == 9);
    idle(2); @(negedge clk);
    check("tile0_ready_idx", {bus.weights_ready, bus.tile_idx}, 'b1_000);
    tick(); pulse_consume();
    for (int i = 10; i <= 18; i++) send(8'(i), i == 18);
    idle(2); @(negedge clk);
    check("tile1_ready_idx", {bus.weights_ready, bus.tile_idx}, 'b1_001);
    tick(); pulse_consume(); idle(2); @(negedge clk);
    check("final_done_busy_err", {bus.done, bus.busy, bus.err_last}, 'b100);
    check("col0_tile0", {q0[0], q0[1], q0[2]}, 'h010203);
    check("col1_tile0", {q1[0], q1[1], q1[2]}, 'h040506);
    check("col2_tile0", {q2[0], q2[1], q2[2]}, 'h070809);
    check("col0_tile1", {q0[3], q0[4], q0[5]}, 'h0A0B0C);
    check("col2_tile1", {q2[3], q2[4], q2[5]}, 'h101112);
    tick();

    // Backpressure with idle gaps
    pulse_start(); clear_log();
    for (int i = 1; i <= 9; i++) begin
      if (i % 3 == 2) idle(1);
      send(8'(8'h40 + i), i == 9);
    end
    idle(2);
    check("gap_push_count", push_cnt, 9);
    check("gap_col1_order", {q1[0], q1[1], q1[2]}, 'h444546);

    // Early s_last on byte 5
    pulse_start();
    for (int i = 1; i <= 9; i++) begin
      send(8'(8'h30 + i), i == 5 || i == 9);
      if (i == 4 || i == 5) begin
        @(negedge clk);
        check(i == 4 ? "err_before_early_last" : "err_after_early_last", bus.err_last, i == 5);
        tick();
      end
    end
    idle(2); @(negedge clk);
    check("err_sticky_in_ready", {bus.weights_ready, bus.err_last}, 'b11);
    tick();

    // Abort after 4 bytes
    pulse_start(); @(negedge clk);
    check("err_cleared_in_clear", {bus.wf_reset, bus.err_last}, 'b10);
    tick(); clear_log();
    for (int i = 1; i <= 4; i++) send(8'(8'h50 + i), 1'b0);
    pulse_start(); @(negedge clk);
    check("abort_push_count", push_cnt, 4);
    check("abort_clear_state", {bus.wf_reset, bus.tile_idx}, 'b1_000);
    tick(); clear_log();
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) pulse_consume();
      send(8'(8'h20 + i), i == 9);
    end
    idle(1);
    check("restart_col0", {q0[0], q0[1], q0[2]}, 'h212223);
    check("restart_col2", {q2[0], q2[1], q2[2]}, 'h272829);

    // s_valid during READY is ignored
    bus.s_valid = 1'b1; bus.s_data = 8'hEE; idle(3); bus.s_valid = 1'b0;
    check("ready_ignores_valid", push_cnt, 9);

    // Reset while READY with tile 1
    pulse_consume();
    for (int i = 1; i <= 9; i++) send(8'(8'h60 + i), i == 9);
    idle(1);
    rst_n = 1'b0; @(negedge clk);
    check("reset_mid_run", int'(dut_vec()), 0);
    #2 rst_n = 1'b1;
    tick(); clear_log();
    bus.s_valid = 1'b1; bus.s_last = 1'b1; idle(4); bus.s_valid = 1'b0; bus.s_last = 1'b0;
    check("no_accept_without_start", push_cnt, 0);

    // Random traffic
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      bus.start = ($urandom % 150 == 0) || (m.phase == P_DONE && $urandom % 4 == 0);
      bus.s_valid = ($urandom % 3) != 0;
      bus.s_data = 8'($urandom);
      bus.s_last = (m.n == TILE - 1) ^ ($urandom % 20 == 0);
      bus.weights_consumed = ($urandom % 5) == 0;
      tick();
    end
    bus.start = 0; bus.s_valid = 0; bus.s_last = 0; bus.weights_consumed = 0;
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/weight_tile_sequencer.md
Name: weight_tile_sequencer

Overview:
- Sequences host weight bytes into the 3-column dual weight FIFO, one 3x3 tile per MLP layer.
- Accepts a byte stream over a valid/ready handshake and routes bytes column-major into the three column push strobes.
- Raises weights_ready to the MLP controller and advances to the next layer's tile once the controller reports the tile consumed.
- Sits between the host/DMA byte interface and the dual weight FIFO plus MLP FSM, replacing manual per-column pushes.

Parameters:
- ROWS, 3, bytes per column (systolic array rows).
- COLS, 3, columns per tile; fixed to 3 by the push port count.
- NUM_LAYERS, 2, tiles per inference run; valid range 1..8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; begins a new run and aborts any run in progress.
- s_valid  in  1  input byte valid.
- s_data  in  8  weight byte.
- s_last  in  1  marks the final byte of a tile.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- wf_push_col0  out  1  push strobe, column 0 FIFO.
- wf_push_col1  out  1  push strobe, column 1 FIFO.
- wf_push_col2  out  1  push strobe, column 2 FIFO.
- wf_data  out  8  byte accompanying a push.
- wf_reset  out  1  one-cycle FIFO clear pulse.
- weights_ready  out  1  current tile fully pushed.
- weights_consumed  in  1  pulse from the MLP FSM: tile taken.
- tile_idx  out  3  index of the tile being filled or held.
- busy  out  1  high in CLEAR, FILL and READY.
- done  out  1  all NUM_LAYERS tiles consumed.
- err_last  out  1  sticky s_last protocol error.

Behaviour:
- Reset: state IDLE; every output 0, including tile_idx and wf_data; row and column counters 0.
- States and transitions:
  - IDLE: start -> CLEAR.
  - CLEAR: lasts exactly 1 cycle, during which wf_reset=1. It clears tile_idx, the counters and err_last, then -> FILL.
  - FILL:
    - s_ready = (state==FILL) && !start, combinational.
    - Each accepted byte is registered. The next cycle drives wf_data=byte with exactly one push strobe high, selected by the column counter. Push latency is 1 cycle.
    - Byte order: bytes 0..ROWS-1 -> col0, the next ROWS -> col1, the last ROWS -> col2.
    - The row counter wraps at ROWS-1 and then increments the column counter.
    - Acceptance of byte ROWS*COLS-1 -> READY; the counters return to 0.
  - READY:
    - s_ready=0; weights_ready=1.
    - The final push occurs in the first READY cycle.
    - On weights_consumed: if tile_idx==NUM_LAYERS-1 -> DONE. Otherwise tile_idx+1 and -> FILL. In both cases weights_ready drops the next cycle.
  - DONE: done=1, s_ready=0; start -> CLEAR.
- Push strobes are 0 in every cycle without a pending registered byte. No two strobes are ever high together.
- s_last rule: s_last must be 1 exactly on the final byte of each tile. Any mismatch (early s_last or missing s_last) sets err_last. The byte is still accepted, and the tile boundary is decided by the count only. err_last clears only in CLEAR or on reset.
- weights_consumed outside READY is ignored.
- s_valid outside FILL is ignored; data is not accepted.
- start in any state (including FILL, READY or DONE) aborts and -> CLEAR.
  - A byte presented in the same cycle as start is not accepted.
  - A push already registered from the previous cycle still issues. It is issued in the CLEAR cycle, before the FIFO clear takes effect.
- An async reset mid-run returns immediately to the reset values; no partial push is issued after reset is released.
- All outputs are registered except s_ready.

Test Plan:
- Two-layer run:
  - Stimulus: start; bytes 0x01..0x09 with s_last on 0x09; weights_consumed; bytes 0x0A..0x12 with s_last on 0x12; weights_consumed.
  - Response: col0 receives 01,02,03; col1 receives 04,05,06; col2 receives 07,08,09. weights_ready and tile_idx=0, then tile_idx=1. Second tile pushes 0A..12. Final state done=1, busy=0, err_last=0.
- Backpressure and gaps: s_valid toggled 1,0,1,1,0,... over one tile -> exactly 9 pushes in order, each one cycle after its handshake. No push on idle cycles.
- Early s_last on byte 5 of 9 -> err_last=1 from the next cycle. The tile still completes after byte 9; err_last stays 1 until the next start.
- Abort: start after 4 bytes accepted -> 4th push still issues, wf_reset pulses for 1 cycle, tile_idx=0. The following 9 bytes start again at col0 row0.
- Ignored inputs:
  - weights_consumed during FILL -> no state change.
  - s_valid=1 during READY -> s_ready=0 and no push.
- Reset assertion while in READY with tile_idx=1 -> all outputs 0 and IDLE. After release, start is required before any byte is accepted.
